// File: rtl/cam_pattern_gen.sv
// OV7670-style camera emulator: VSYNC/HREF/PCLK/D frame timing with selectable test patterns.
// Define CAMGEN_FRAME_CNT_EN to stamp 8'hFC and a wrapping frame count into active line 0.
module cam_pattern_gen #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_BLANK   = 144,
  parameter int unsigned VS_LINES  = 3,
  parameter int unsigned VBP_LINES = 17,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned VFP_LINES = 10,
  parameter int unsigned CW        = 12
) (
  input  logic       xipMCLK,
  input  logic       xinRESET,
  input  logic       xipEN,
  input  logic [1:0] xipMODE,
  input  logic       xipCAM_PWDN,
  input  logic       xinCAM_RESET,
  output logic       xopCAM_VSYNC,
  output logic       xopCAM_HREF,
  output logic       xopCAM_PCLK,
  output logic [7:0] xopCAM_D,
  output logic       xopFRAME_END
);

  localparam logic [CW-1:0] HLast   = CW'(H_ACTIVE + H_BLANK - 1);
  localparam logic [CW-1:0] HActive = CW'(H_ACTIVE);
  localparam logic [CW-1:0] VsLast  = CW'(VS_LINES - 1);
  localparam logic [CW-1:0] VbpLast = CW'(VBP_LINES - 1);
  localparam logic [CW-1:0] VactLast = CW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] VfpLast = CW'(VFP_LINES - 1);
  // Narrow lines would give a zero bar width; clamp so the divide stays defined.
  localparam int unsigned   BarW    = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

  typedef enum logic [2:0] {StIdle, StVsync, StVback, StActive, StVfront} stateT;

  stateT         stateQ, stateD;
  logic [CW-1:0] hcntQ, hcntD;
  logic [CW-1:0] vcntQ, vcntD;
  logic [1:0]    modeQ, modeD;
  logic          pclkQ, pclkD;
  logic          vsyncQ, vsyncD;
  logic          hrefQ, hrefD;
  logic [7:0]    dataQ, dataD;
  logic          frameEndQ, frameEndD;
`ifdef CAMGEN_FRAME_CNT_EN
  logic [7:0]    frameCntQ, frameCntD;
`endif

  function automatic logic [7:0] patternByte(input logic [1:0] mode, input logic [CW-1:0] h,
                                             input logic [CW-1:0] v);
    logic [7:0] bar;
    bar = 8'((h / CW'(BarW)) & CW'(7));
    unique case (mode)
      2'd0:    patternByte = 8'(h);
      2'd1:    patternByte = 8'(v);
      2'd2:    patternByte = bar * 8'd36;
      default: patternByte = (h[0] ^ v[0]) ? 8'h55 : 8'hAA;
    endcase
  endfunction

  always_comb begin
    stateD    = stateQ;
    hcntD     = hcntQ;
    vcntD     = vcntQ;
    modeD     = modeQ;
    frameEndD = 1'b0;
    pclkD     = (stateQ != StIdle) ? ~pclkQ : 1'b0;
`ifdef CAMGEN_FRAME_CNT_EN
    frameCntD = frameCntQ;
`endif

    if (stateQ == StIdle) begin
      if (xipEN) begin
        stateD = StVsync;
        hcntD  = '0;
        vcntD  = '0;
        modeD  = xipMODE;
      end
    end else if (pclkQ) begin
      // Step point: PCLK falls on this edge, so the consumer sees stable data at its rise.
      if (hcntQ != HLast) begin
        hcntD = hcntQ + CW'(1);
      end else begin
        hcntD = '0;
        vcntD = vcntQ + CW'(1);
        unique case (stateQ)
          StVsync: begin
            if (vcntQ == VsLast) begin
              stateD = StVback;
              vcntD  = '0;
            end
          end
          StVback: begin
            if (vcntQ == VbpLast) begin
              stateD = StActive;
              vcntD  = '0;
            end
          end
          StActive: begin
            if (vcntQ == VactLast) begin
              stateD = StVfront;
              vcntD  = '0;
            end
          end
          StVfront: begin
            if (vcntQ == VfpLast) begin
              frameEndD = 1'b1;
              vcntD     = '0;
`ifdef CAMGEN_FRAME_CNT_EN
              frameCntD = frameCntQ + 8'd1;
`endif
              if (xipEN) begin
                stateD = StVsync;
                modeD  = xipMODE;
              end else begin
                stateD = StIdle;
              end
            end
          end
          default: stateD = StIdle;
        endcase
      end
    end

    // Outputs are registered from next-state values so they move with the step edge.
    vsyncD = (stateD == StVsync);
    hrefD  = (stateD == StActive) && (hcntD < HActive);
    dataD  = 8'h00;
    if (hrefD) begin
      dataD = patternByte(modeD, hcntD, vcntD);
`ifdef CAMGEN_FRAME_CNT_EN
      if (vcntD == '0 && hcntD == '0) begin
        dataD = 8'hFC;
      end else if (vcntD == '0 && hcntD == CW'(1)) begin
        dataD = frameCntQ;
      end
`endif
    end
  end

  always_ff @(posedge xipMCLK) begin
    if (!xinRESET || !xinCAM_RESET || xipCAM_PWDN) begin
      stateQ    <= StIdle;
      hcntQ     <= '0;
      vcntQ     <= '0;
      modeQ     <= 2'd0;
      pclkQ     <= 1'b0;
      vsyncQ    <= 1'b0;
      hrefQ     <= 1'b0;
      dataQ     <= 8'h00;
      frameEndQ <= 1'b0;
`ifdef CAMGEN_FRAME_CNT_EN
      frameCntQ <= 8'h00;
`endif
    end else begin
      stateQ    <= stateD;
      hcntQ     <= hcntD;
      vcntQ     <= vcntD;
      modeQ     <= modeD;
      pclkQ     <= pclkD;
      vsyncQ    <= vsyncD;
      hrefQ     <= hrefD;
      dataQ     <= dataD;
      frameEndQ <= frameEndD;
`ifdef CAMGEN_FRAME_CNT_EN
      frameCntQ <= frameCntD;
`endif
    end
  end

  assign xopCAM_VSYNC = vsyncQ;
  assign xopCAM_HREF  = hrefQ;
  assign xopCAM_PCLK  = pclkQ;
  assign xopCAM_D     = dataQ;
  assign xopFRAME_END = frameEndQ;

endmodule

// File: tb/tb_cam_pattern_gen.sv
// Randomized bench for cam_pattern_gen: a frame-time reference model predicts sync/clock lines
// each cycle and queues the expected pixel bytes, which a separate monitor checks at PCLK rise.
module tb_cam_pattern_gen;
  localparam int unsigned HA = 16, HB = 4, VS = 2, VBP = 1, VA = 3, VFP = 1, CW = 12;
  localparam int unsigned LineLen  = HA + HB;
  localparam int unsigned FrameLen = (VS + VBP + VA + VFP) * LineLen * 2;

  logic       mclk = 1'b0;
  logic       rstn = 1'b0;
  logic       en = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       pwdn = 1'b0;
  logic       camRstn = 1'b1;
  logic       vsync, href, pclk, frameEnd;
  logic [7:0] d;

  cam_pattern_gen #(
    .H_ACTIVE(HA), .H_BLANK(HB), .VS_LINES(VS), .VBP_LINES(VBP),
    .V_ACTIVE(VA), .VFP_LINES(VFP), .CW(CW)
  ) dut (
    .xipMCLK(mclk), .xinRESET(rstn), .xipEN(en), .xipMODE(mode),
    .xipCAM_PWDN(pwdn), .xinCAM_RESET(camRstn),
    .xopCAM_VSYNC(vsync), .xopCAM_HREF(href), .xopCAM_PCLK(pclk),
    .xopCAM_D(d), .xopFRAME_END(frameEnd)
  );

  always #5 mclk = ~mclk;

  int errors = 0;
  int checks = 0;
  logic [7:0] expQ[$];

  // Reference model: k counts MCLK edges since the frame started.
  bit run = 1'b0;
  int k = 0;
  bit fe = 1'b0;
`ifdef CAMGEN_FRAME_CNT_EN
  logic [7:0] fcnt = 8'h00;
`endif

  function automatic logic [7:0] refByte(input int m, input int r, input int h);
    case (m)
      0:       return 8'(h % 256);
      1:       return 8'(r % 256);
      2:       return 8'(((h / (HA / 8)) % 8) * 36);
      default: return (((h + r) % 2) == 1) ? 8'h55 : 8'hAA;
    endcase
  endfunction

  task automatic startFrame(input int m);
    for (int r = 0; r < int'(VA); r++) begin
      for (int h = 0; h < int'(HA); h++) begin
        logic [7:0] b;
        b = refByte(m, r, h);
`ifdef CAMGEN_FRAME_CNT_EN
        if (r == 0 && h == 0) b = 8'hFC;
        if (r == 0 && h == 1) b = fcnt;
`endif
        expQ.push_back(b);
      end
    end
  endtask

  task automatic modelEdge();
    if (!rstn || !camRstn || pwdn) begin
      run = 1'b0;
      k = 0;
      fe = 1'b0;
      expQ.delete();
`ifdef CAMGEN_FRAME_CNT_EN
      fcnt = 8'h00;
`endif
    end else if (!run) begin
      fe = 1'b0;
      if (en) begin
        run = 1'b1;
        k = 0;
        startFrame(int'(mode));
      end
    end else begin
      k++;
      fe = 1'b0;
      if (k == int'(FrameLen)) begin
        fe = 1'b1;
        checks++;
        if (expQ.size() != 0) begin
          errors++;
          $display("FAIL bytesLeft t=%0t got %0d undelivered bytes at frame end, required 0",
                   $time, expQ.size());
        end
`ifdef CAMGEN_FRAME_CNT_EN
        fcnt = fcnt + 8'd1;
`endif
        k = 0;
        if (en) startFrame(int'(mode));
        else run = 1'b0;
      end
    end
  endtask

  task automatic cycle(input bit e, input logic [1:0] m, input bit r, input bit cr, input bit pd);
    int s, line, h;
    logic [3:0] expCtl;
    bit expH;
    en = e;
    mode = m;
    rstn = r;
    camRstn = cr;
    pwdn = pd;
    @(posedge mclk);
    modelEdge();
    @(negedge mclk);
    s = k / 2;
    line = s / int'(LineLen);
    h = s % int'(LineLen);
    expH = run && line >= int'(VS + VBP) && line < int'(VS + VBP + VA) && h < int'(HA);
    expCtl = {run && line < int'(VS), expH, run && (k % 2 == 1), fe};
    checks++;
    if ({vsync, href, pclk, frameEnd} !== expCtl) begin
      errors++;
      $display("FAIL ctrl t=%0t got vsync/href/pclk/fend=%b required %b", $time,
               {vsync, href, pclk, frameEnd}, expCtl);
    end
    if (!expH) begin
      checks++;
      if (d !== 8'h00) begin
        errors++;
        $display("FAIL dIdle t=%0t got D=%h required 00", $time, d);
      end
    end
  endtask

  // Monitor: consumes one byte per PCLK high phase while HREF is asserted.
  initial begin
    forever begin
      @(negedge mclk);
      if (pclk === 1'b1 && href === 1'b1) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("FAIL pixel t=%0t got unexpected byte %h, required no byte", $time, d);
        end else begin
          logic [7:0] exp;
          exp = expQ.pop_front();
          if (d !== exp) begin
            errors++;
            $display("FAIL pixel t=%0t got D=%h required %h", $time, d, exp);
          end
        end
      end
    end
  end

  initial begin
    bit e;
    int pdLeft;
    int ev;
    for (int i = 0; i < 3; i++) cycle(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 2'd3, 1'b1, 1'b1, 1'b0);
    // One full frame per mode, mode held constant across each frame.
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < int'(FrameLen); i++) cycle(1'b1, 2'(f), 1'b1, 1'b1, 1'b0);
    end
    // Drop EN early in a frame: it must complete, then go idle.
    for (int i = 0; i < 200; i++) cycle(1'b1, 2'd1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 400; i++) cycle(1'b0, 2'd2, 1'b1, 1'b1, 1'b0);
    // Random run: wandering EN, per-cycle MODE noise, sporadic reset/CAM reset/PWDN.
    e = 1'b1;
    pdLeft = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(199) == 0) e = ~e;
      ev = int'($urandom_range(499));
      if (ev == 2) pdLeft = 5;
      cycle(e, 2'($urandom_range(3)), ev != 0, ev != 1, pdLeft > 0);
      if (pdLeft > 0) pdLeft--;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cam_pattern_gen.md
Name: cam_pattern_gen

Overview:
- Synthesizable camera-sensor emulator that sits directly upstream of the camera capture input of top.
- Generates OV7670-style frame timing (VSYNC, HREF, PCLK, D[7:0]) with selectable test patterns from the master clock.
- Used on board in place of the sensor for bring-up, and in simulation as the stimulus source for the xipCAM_* pins.

Parameters:
H_ACTIVE, 640, bytes per line with HREF high (one byte per PCLK period)
H_BLANK, 144, PCLK periods per line with HREF low
VS_LINES, 3, lines with VSYNC high
VBP_LINES, 17, back-porch lines after VSYNC, HREF low
V_ACTIVE, 480, lines carrying HREF pulses
VFP_LINES, 10, front-porch lines, HREF low
CW, 12, width of the horizontal and vertical counters; must hold max(H_ACTIVE+H_BLANK, V_ACTIVE)

Ports:
xipMCLK  in  1  master clock; all logic on the rising edge
xinRESET  in  1  reset, synchronous, active-low
xipEN  in  1  run request; sampled only at frame boundaries
xipMODE  in  2  pattern select; sampled at frame start
xipCAM_PWDN  in  1  power-down; 1 forces idle outputs
xinCAM_RESET  in  1  sensor reset, active-low; 0 restarts like xinRESET
xopCAM_VSYNC  out  1  frame sync, active high
xopCAM_HREF  out  1  line valid
xopCAM_PCLK  out  1  pixel clock, xipMCLK/2
xopCAM_D  out  8  pixel byte
xopFRAME_END  out  1  one-MCLK pulse at the end of each frame

Behaviour:
- Reset: on a rising edge with xinRESET=0, or xinCAM_RESET=0, or xipCAM_PWDN=1, the block enters ST_IDLE. All outputs, counters and the PCLK register clear to 0 on that same edge.
- PCLK: registered toggle every xipMCLK while not in ST_IDLE. It is held at 0 in ST_IDLE.
- Step point: the timing state and counters advance only on the MCLK edge where PCLK goes 1->0. VSYNC, HREF and D therefore change on the PCLK falling edge and are stable at the PCLK rising edge, where the consumer samples them.
- One line = H_ACTIVE+H_BLANK steps, tracked by hcnt 0..H_ACTIVE+H_BLANK-1.
- States:
  - ST_IDLE: if xipEN=1, go to ST_VSYNC, start PCLK, hcnt=vcnt=0, latch xipMODE.
  - ST_VSYNC: VSYNC=1 for VS_LINES lines, then go to ST_VBACK.
  - ST_VBACK: VBP_LINES lines, then go to ST_ACTIVE.
  - ST_ACTIVE: HREF=1 while hcnt<H_ACTIVE, else 0. vcnt counts lines 0..V_ACTIVE-1. After line V_ACTIVE-1, go to ST_VFRONT.
  - ST_VFRONT: VFP_LINES lines. On the last step: pulse xopFRAME_END. Then, if xipEN=1, go to ST_VSYNC (re-latch MODE); otherwise go to ST_IDLE.
- VSYNC and HREF are mutually exclusive.
- Frame length = (VS_LINES+VBP_LINES+V_ACTIVE+VFP_LINES)*(H_ACTIVE+H_BLANK)*2 MCLK cycles.
- D is 0 whenever HREF=0. While HREF=1, D depends on the latched mode:
  - 0: hcnt[7:0] (ramp, wraps at 256)
  - 1: vcnt[7:0]
  - 2: colour bars = {hcnt/(H_ACTIVE/8)}[2:0] replicated as 8'hX*0x24 truncated to 8 bits, i.e. bar index*36 mod 256
  - 3: checker = 8'h55 if hcnt[0]^vcnt[0] else 8'hAA
- xipEN deasserted mid-frame: the frame completes. xipEN is not rechecked until ST_VFRONT ends.
- xipMODE changes mid-frame are ignored.
- Reset, PWDN or CAM reset mid-frame: abort on the same edge, with no FRAME_END pulse.
- Simultaneous xinRESET=0 and xipEN=1: reset wins.
- Counters are sized so they never wrap within a frame. Parameter sets that break this are illegal.

Optional Feature:
- Macro CAMGEN_FRAME_CNT_EN.
- Defined: an 8-bit frame counter (reset 0) increments at each FRAME_END. The first two bytes of active line 0 carry 8'hFC and then the counter value, replacing the pattern bytes. The counter wraps 255->0.
- Undefined: no counter logic, and pattern bytes are unmodified.

Test Plan:
- Params H_ACTIVE=4, H_BLANK=2, VS=1, VBP=1, V_ACTIVE=2, VFP=1; MODE=0; EN=1 after reset -> VSYNC high 12 MCLK; two HREF bursts, each 8 MCLK wide, carrying D=00,01,02,03; FRAME_END every 60 MCLK.
- Same params, MODE=3 -> line 0 bytes AA,55,AA,55; line 1 bytes 55,AA,55,AA; D=0 outside HREF.
- EN dropped during line 0 of ST_ACTIVE -> frame finishes, one FRAME_END, then PCLK=0 and all outputs 0; EN high again -> VSYNC starts 1 MCLK after.
- xinRESET=0 for one cycle mid-HREF -> next edge all outputs 0, no FRAME_END; restart gives a full-length VSYNC.
- xipCAM_PWDN=1 for 5 cycles -> outputs 0 throughout; after release with EN=1, a new frame begins at ST_VSYNC.
- With CAMGEN_FRAME_CNT_EN defined, run 3 frames, MODE=0 -> line 0 begins FC,00 / FC,01 / FC,02, followed by 02,03.
